// File: rtl/ray_marcher_if.sv
// Handshake bundles around the ray marcher: ray_if faces the pixel
// scheduler (master = scheduler, slave = marcher); sdf_if faces menger_sdf
// (master = marcher, slave = SDF evaluator).

interface ray_if;
    logic        ray_start;
    logic [31:0] ray_ox, ray_oy, ray_oz;
    logic [31:0] ray_dx, ray_dy, ray_dz;
    logic        ray_busy;
    logic        ray_done;
    logic        ray_hit;
    logic        ray_timeout;
    logic [7:0]  ray_steps;
    logic [31:0] ray_depth;
    logic [7:0]  ray_red, ray_green, ray_blue;

    modport master (
        output ray_start, ray_ox, ray_oy, ray_oz, ray_dx, ray_dy, ray_dz,
        input  ray_busy, ray_done, ray_hit, ray_timeout, ray_steps, ray_depth,
               ray_red, ray_green, ray_blue
    );
    modport slave (
        input  ray_start, ray_ox, ray_oy, ray_oz, ray_dx, ray_dy, ray_dz,
        output ray_busy, ray_done, ray_hit, ray_timeout, ray_steps, ray_depth,
               ray_red, ray_green, ray_blue
    );
endinterface

interface sdf_if;
    logic        sdf_start;
    logic [31:0] sdf_x, sdf_y, sdf_z;
    logic        sdf_done;
    logic [31:0] sdf_dist;
    logic [7:0]  sdf_red, sdf_green, sdf_blue;

    modport master (
        output sdf_start, sdf_x, sdf_y, sdf_z,
        input  sdf_done, sdf_dist, sdf_red, sdf_green, sdf_blue
    );
    modport slave (
        input  sdf_start, sdf_x, sdf_y, sdf_z,
        output sdf_done, sdf_dist, sdf_red, sdf_green, sdf_blue
    );
endinterface

// File: rtl/ray_marcher.sv
// Sphere-tracing initiator: marches one ray through the SDF, one query in
// flight at a time, until hit, miss (depth or step limit) or SDF timeout.

module ray_marcher #(
    parameter int FRAC_BITS   = 10,
    parameter int MAX_STEPS   = 64,
    parameter int HIT_EPS     = 16,
    parameter int MAX_DIST    = 102400,
    parameter int SDF_TIMEOUT = 4096
) (
    input  logic   clk_in,
    input  logic   rst_in,
    ray_if.slave   ray,
    sdf_if.master  sdf
);
    localparam int CNT_W = $clog2(SDF_TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0][31:0]   pos_q, pos_d;
    logic [2:0][31:0]   dir_q, dir_d;
    logic [31:0]        depth_q, depth_d;
    logic [7:0]         steps_q, steps_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        dist_q, dist_d;
    logic [23:0]        srgb_q, srgb_d;   // colour of the last SDF answer
    logic [23:0]        rgb_q, rgb_d;     // reported colour
    logic               hit_q, hit_d;
    logic               tmo_q, tmo_d;

    logic signed [63:0] prod [3];
    logic [2:0][31:0]   adv;
    logic signed [32:0] depth_sum;

    // Per-axis advance (dir*dist)>>>FRAC_BITS and the candidate depth.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod[i] = $signed(dir_q[i]) * $signed(dist_q);
            adv[i]  = 32'(prod[i] >>> FRAC_BITS);
        end
        depth_sum = $signed({1'b0, depth_q}) + $signed({dist_q[31], dist_q});
    end

    // Next-state and datapath updates; everything holds by default.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        depth_d = depth_q;
        steps_d = steps_q;
        cnt_d   = cnt_q;
        dist_d  = dist_q;
        srgb_d  = srgb_q;
        rgb_d   = rgb_q;
        hit_d   = hit_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (ray.ray_start) begin
                    pos_d   = {ray.ray_oz, ray.ray_oy, ray.ray_ox};
                    dir_d   = {ray.ray_dz, ray.ray_dy, ray.ray_dx};
                    depth_d = '0;
                    steps_d = '0;
                    rgb_d   = '0;
                    hit_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                steps_d = steps_q + 8'd1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sdf.sdf_done) begin
                    dist_d  = sdf.sdf_dist;
                    srgb_d  = {sdf.sdf_red, sdf.sdf_green, sdf.sdf_blue};
                    state_d = S_EVAL;
                end else if (cnt_q == CNT_W'(SDF_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EVAL: begin
                // Negative distances (inside the surface) count as hits too.
                if ($signed(dist_q) < HIT_EPS) begin
                    hit_d   = 1'b1;
                    rgb_d   = srgb_q;
                    state_d = S_DONE;
                end else if (depth_sum > 33'(MAX_DIST)) begin
                    state_d = S_DONE;
                end else if (steps_q == 8'(MAX_STEPS)) begin
                    state_d = S_DONE;
                end else begin
                    depth_d = (depth_sum > 33'sh0_7FFF_FFFF) ? 32'h7FFF_FFFF
                                                             : depth_sum[31:0];
                    for (int i = 0; i < 3; i++) pos_d[i] = pos_q[i] + adv[i];
                    state_d = S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            dir_q   <= '0;
            depth_q <= '0;
            steps_q <= '0;
            cnt_q   <= '0;
            dist_q  <= '0;
            srgb_q  <= '0;
            rgb_q   <= '0;
            hit_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            depth_q <= depth_d;
            steps_q <= steps_d;
            cnt_q   <= cnt_d;
            dist_q  <= dist_d;
            srgb_q  <= srgb_d;
            rgb_q   <= rgb_d;
            hit_q   <= hit_d;
            tmo_q   <= tmo_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign sdf.sdf_start   = (state_q == S_ISSUE);
    assign sdf.sdf_x       = pos_q[0];
    assign sdf.sdf_y       = pos_q[1];
    assign sdf.sdf_z       = pos_q[2];

    assign ray.ray_busy    = (state_q != S_IDLE);
    assign ray.ray_done    = (state_q == S_DONE);
    assign ray.ray_hit     = hit_q;
    assign ray.ray_timeout = tmo_q;
    assign ray.ray_steps   = steps_q;
    assign ray.ray_depth   = depth_q;
    assign ray.ray_red     = rgb_q[23:16];
    assign ray.ray_green   = rgb_q[15:8];
    assign ray.ray_blue    = rgb_q[7:0];
endmodule

// File: tb/tb_ray_marcher.sv
// Directed bench for ray_marcher with a plane SDF stub (dist = 5120 - z).

module tb_ray_marcher;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    ray_if rif ();
    sdf_if sif ();

    ray_marcher dut (.clk_in(clk_in), .rst_in(rst_in), .ray(rif.slave), .sdf(sif.master));

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mode   = 0;   // 0 plane, 1 const 1024, 2 silent, 3 -200 then plane
    int nq     = 0;
    int ndone  = 0;
    int t_q    = 0;
    int t_done = 0;
    int qlog [8];
    bit pend   = 0;
    int lat    = 0;
    logic [31:0] resp;

    always @(posedge clk_in) cyc++;

    // SDF stub: 3-cycle latency, one-cycle done pulse, logs query z.
    always @(negedge clk_in) begin
        if (rst_in) begin
            pend         = 0;
            sif.sdf_done = 1'b0;
        end else begin
            sif.sdf_done = 1'b0;
            if (pend) begin
                if (lat == 0) begin
                    pend         = 0;
                    sif.sdf_done = 1'b1;
                    sif.sdf_dist = resp;
                end else lat--;
            end else if (sif.sdf_start) begin
                pend = (mode != 2);
                lat  = 2;
                t_q  = cyc;
                if (nq < 8) qlog[nq] = $signed(sif.sdf_z);
                case (mode)
                    1:       resp = 32'd1024;
                    3:       resp = (nq == 0) ? -32'sd200 : 32'd5120 - sif.sdf_z;
                    default: resp = 32'd5120 - sif.sdf_z;
                endcase
                nq++;
            end
            if (rif.ray_done) ndone++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Launch one ray and wait (bounded) for ray_done; optionally poke ray_start mid-flight.
    task automatic run_ray(input string tag, input int ox, oy, oz, dx, dy, dz,
                           input bit poke, input int budget);
        bit seen = 0;
        @(negedge clk_in);
        rif.ray_ox = ox; rif.ray_oy = oy; rif.ray_oz = oz;
        rif.ray_dx = dx; rif.ray_dy = dy; rif.ray_dz = dz;
        rif.ray_start = 1'b1;
        nq = 0; ndone = 0;
        @(negedge clk_in);
        rif.ray_start = 1'b0;
        check({tag, "_sdf_start_n1"}, 32'(sif.sdf_start), 32'd1);
        check({tag, "_busy"}, 32'(rif.ray_busy), 32'd1);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (rif.ray_done) begin seen = 1; break; end
            if (poke && i == 10) begin
                rif.ray_oz = 999; rif.ray_dz = 2048; rif.ray_start = 1'b1;
            end else rif.ray_start = 1'b0;
        end
        rif.ray_start = 1'b0;
        t_done = cyc;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_in_done"}, 32'(rif.ray_busy), 32'd1);
    endtask

    initial begin
        rif.ray_start = 0;
        rif.ray_ox = 0; rif.ray_oy = 0; rif.ray_oz = 0;
        rif.ray_dx = 0; rif.ray_dy = 0; rif.ray_dz = 0;
        sif.sdf_done = 0; sif.sdf_dist = 0;
        sif.sdf_red = 8'd10; sif.sdf_green = 8'd20; sif.sdf_blue = 8'd30;

        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_busy", 32'(rif.ray_busy), 32'd0);
        check("rst_done", 32'(rif.ray_done), 32'd0);
        check("rst_sdf_start", 32'(sif.sdf_start), 32'd0);
        check("rst_steps", 32'(rif.ray_steps), 32'd0);
        check("rst_depth", rif.ray_depth, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Forward ray hits plane at z=5120 on the second query; start in DONE ignored.
        mode = 0;
        run_ray("fwd", 0, 0, 0, 0, 0, 1024, 0, 200);
        rif.ray_start = 1'b1;
        check("fwd_hit", 32'(rif.ray_hit), 32'd1);
        check("fwd_steps", 32'(rif.ray_steps), 32'd2);
        check("fwd_depth", rif.ray_depth, 32'd5120);
        check("fwd_rgb", {8'd0, rif.ray_red, rif.ray_green, rif.ray_blue}, 32'h000A141E);
        check("fwd_timeout", 32'(rif.ray_timeout), 32'd0);
        @(negedge clk_in);
        rif.ray_start = 1'b0;
        check("fwd_idle_after_done", 32'(rif.ray_busy), 32'd0);
        repeat (3) @(negedge clk_in);
        check("fwd_done_once", 32'(ndone), 32'd1);
        check("fwd_held_depth", rif.ray_depth, 32'd5120);
        check("fwd_no_requery", 32'(nq), 32'd2);

        // Backward ray recedes until depth limit; start pulsed mid-flight is ignored.
        run_ray("bwd", 0, 0, 0, 0, 0, -1024, 1, 400);
        check("bwd_hit", 32'(rif.ray_hit), 32'd0);
        check("bwd_steps", 32'(rif.ray_steps), 32'd5);
        check("bwd_depth", rif.ray_depth, 32'd76800);
        check("bwd_rgb", {8'd0, rif.ray_red, rif.ray_green, rif.ray_blue}, 32'd0);
        check("bwd_q0", qlog[0], 32'd0);
        check("bwd_q1", qlog[1], -32'sd5120);
        check("bwd_q2", qlog[2], -32'sd15360);
        check("bwd_q3", qlog[3], -32'sd35840);
        check("bwd_q4", qlog[4], -32'sd76800);

        // Constant distance: step limit
        mode = 1;
        run_ray("steps", 0, 0, 0, 0, 0, 1024, 0, 1000);
        check("steps_hit", 32'(rif.ray_hit), 32'd0);
        check("steps_steps", 32'(rif.ray_steps), 32'd64);
        check("steps_depth", rif.ray_depth, 32'd64512);
        check("steps_rgb", {8'd0, rif.ray_red, rif.ray_green, rif.ray_blue}, 32'd0);

        // Silent SDF: timeout
        mode = 2;
        run_ray("tmo", 0, 0, 0, 0, 0, 1024, 0, 4300);
        check("tmo_timeout", 32'(rif.ray_timeout), 32'd1);
        check("tmo_hit", 32'(rif.ray_hit), 32'd0);
        check("tmo_steps", 32'(rif.ray_steps), 32'd1);
        check("tmo_latency_ok", 32'(t_done - t_q <= 4096 + 3), 32'd1);

        // Negative first distance: immediate hit
        mode = 3;
        run_ray("neg", 0, 0, 0, 0, 0, 1024, 0, 200);
        check("neg_hit", 32'(rif.ray_hit), 32'd1);
        check("neg_steps", 32'(rif.ray_steps), 32'd1);
        check("neg_depth", rif.ray_depth, 32'd0);
        check("neg_timeout", 32'(rif.ray_timeout), 32'd0);

        // Reset in the middle of WAIT
        mode = 0;
        @(negedge clk_in);
        rif.ray_oz = 0; rif.ray_dz = 1024; rif.ray_start = 1'b1;
        @(negedge clk_in);
        rif.ray_start = 1'b0;
        repeat (2) @(negedge clk_in);
        #1 rst_in = 1'b1;
        #1;
        check("mid_rst_sdf_start", 32'(sif.sdf_start), 32'd0);
        check("mid_rst_busy", 32'(rif.ray_busy), 32'd0);
        check("mid_rst_done", 32'(rif.ray_done), 32'd0);
        check("mid_rst_steps", 32'(rif.ray_steps), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        run_ray("post", 0, 0, 0, 0, 0, 1024, 0, 200);
        check("post_hit", 32'(rif.ray_hit), 32'd1);
        check("post_steps", 32'(rif.ray_steps), 32'd2);
        check("post_depth", rif.ray_depth, 32'd5120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
